// File: rtl/id_ex_issue.sv
// ID/EX issue stage: registers decode outputs, translates ALU op, forwards operands to the ALU.
// Optional macro ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding; otherwise operands come straight from the stage registers.
module id_ex_issue #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [15:0]       imm,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              alu_src,
  input  logic [1:0]        alu_op_main,
  input  logic [5:0]        funct,
  input  logic              reg_write,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              illegal
);

  logic              r_valid, r_reg_write, r_illegal, r_alu_src;
  logic [3:0]        r_alu_op;
  logic [REG_AW-1:0] r_rd, r_rs_addr, r_rt_addr;
  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_ext_imm;

  logic [3:0]        w_alu_op;
  logic              w_illegal;
  logic [DATA_W-1:0] w_ext_imm, w_fwd_a, w_fwd_b;

  always_comb begin
    w_alu_op  = 4'd15;
    w_illegal = 1'b0;
    case (alu_op_main)
      2'b00: w_alu_op = 4'd15;
      2'b01: w_alu_op = 4'd6;
      2'b11: w_alu_op = 4'd1;
      default: begin
        case (funct)
          6'h24:        w_alu_op = 4'd0;
          6'h25:        w_alu_op = 4'd1;
          6'h20, 6'h21: w_alu_op = 4'd15;
          6'h22, 6'h23: w_alu_op = 4'd6;
          6'h2A:        w_alu_op = 4'd7;
          6'h27:        w_alu_op = 4'd12;
          default: begin
            w_alu_op  = 4'd15;
            w_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // ori zero-extends; every other immediate user sign-extends
  assign w_ext_imm = (alu_op_main == 2'b11) ? {{(DATA_W-16){1'b0}}, imm}
                                            : {{(DATA_W-16){imm[15]}}, imm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= '0;
      r_rd        <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_ext_imm   <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= '0;
      r_rd        <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_ext_imm   <= '0;
    end else if (!stall) begin
      r_valid     <= in_valid;
      r_reg_write <= reg_write & in_valid;
      r_illegal   <= w_illegal;
      r_alu_src   <= alu_src;
      r_alu_op    <= w_alu_op;
      r_rd        <= rd_addr;
      r_rs_addr   <= rs_addr;
      r_rt_addr   <= rt_addr;
      r_rs_data   <= rs_data;
      r_rt_data   <= rt_data;
      r_ext_imm   <= w_ext_imm;
    end
  end

`ifdef ID_EX_FWD_EN
  // EX/MEM is younger than MEM/WB so it wins; $zero is never forwarded
  always_comb begin
    w_fwd_a = r_rs_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == r_rs_addr)
      w_fwd_a = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == r_rs_addr)
      w_fwd_a = memwb_result;
  end

  always_comb begin
    w_fwd_b = r_rt_data;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == r_rt_addr)
      w_fwd_b = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == r_rt_addr)
      w_fwd_b = memwb_result;
  end
`else
  logic w_unused;
  assign w_unused = ^{exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result, r_rs_addr, r_rt_addr};
  assign w_fwd_a  = r_rs_data;
  assign w_fwd_b  = r_rt_data;
`endif

  assign in_ready       = ~stall;
  assign out_valid      = r_valid;
  assign out_reg_write  = r_reg_write;
  assign illegal        = r_illegal;
  assign alu_op         = r_alu_op;
  assign out_rd         = r_rd;
  assign alu_x          = w_fwd_a;
  assign alu_y          = r_alu_src ? r_ext_imm : w_fwd_b;
  assign out_store_data = w_fwd_b;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed self-checking bench for id_ex_issue: decode, immediates, forwarding, stall/flush, reset.
module tb_id_ex_issue;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, stall, flush;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic [15:0]       imm;
  logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr;
  logic              alu_src;
  logic [1:0]        alu_op_main;
  logic [5:0]        funct;
  logic              reg_write;
  logic              exmem_reg_write, memwb_reg_write;
  logic [REG_AW-1:0] exmem_rd, memwb_rd;
  logic [DATA_W-1:0] exmem_result, memwb_result;
  logic              out_valid, out_reg_write, illegal;
  logic [DATA_W-1:0] alu_x, alu_y, out_store_data;
  logic [3:0]        alu_op;
  logic [REG_AW-1:0] out_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_issue #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .alu_src(alu_src), .alu_op_main(alu_op_main), .funct(funct),
    .reg_write(reg_write), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .out_valid(out_valid), .alu_x(alu_x),
    .alu_y(alu_y), .alu_op(alu_op), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .illegal(illegal)
  );

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; flush = 0; rs_data = 0; rt_data = 0; imm = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; alu_src = 0; alu_op_main = 2'b00;
    funct = 0; reg_write = 0; exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                       input logic [31:0] rtd, input logic [4:0] rd, input logic [15:0] im,
                       input logic src, input logic [1:0] mop, input logic [5:0] fn);
    in_valid = 1; reg_write = 1; rs_addr = rs; rs_data = rsd; rt_addr = rt; rt_data = rtd;
    rd_addr = rd; imm = im; alu_src = src; alu_op_main = mop; funct = fn;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #3;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_tests++; if (alu_op !== 4'd0) begin n_fail++; $display("FAIL rst_alu_op got %0d want 0", alu_op); end
    n_tests++; if ({alu_x, alu_y, out_store_data} !== '0) begin n_fail++; $display("FAIL rst_data x=%h y=%h sd=%h want 0", alu_x, alu_y, out_store_data); end
    n_tests++; if ({out_reg_write, illegal, out_rd} !== '0) begin n_fail++; $display("FAIL rst_ctl rw=%b ill=%b rd=%0d want 0", out_reg_write, illegal, out_rd); end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_rtype();
    logic [5:0] f_tab [9] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h27, 6'h3F};
    logic [3:0] e_tab [9] = '{4'd0, 4'd1, 4'd15, 4'd15, 4'd6, 4'd6, 4'd7, 4'd12, 4'd15};
    for (int i = 0; i < 9; i++) begin
      idle();
      drive(5'd1, 32'h10, 5'd2, 32'h20, 5'd3, 16'h0, 1'b0, 2'b10, f_tab[i]);
      step();
      n_tests++; if (alu_op !== e_tab[i]) begin n_fail++; $display("FAIL rtype_op funct=%h got %0d want %0d", f_tab[i], alu_op, e_tab[i]); end
      n_tests++; if (illegal !== (i == 8)) begin n_fail++; $display("FAIL rtype_illegal funct=%h got %b want %b", f_tab[i], illegal, (i == 8)); end
    end
    n_tests++; if (alu_y !== 32'h20 || out_rd !== 5'd3 || out_reg_write !== 1'b1) begin n_fail++; $display("FAIL rtype_fields y=%h rd=%0d rw=%b want 20/3/1", alu_y, out_rd, out_reg_write); end
  endtask

  task automatic test_imm();
    idle();
    drive(5'd1, 32'h7, 5'd2, 32'h9, 5'd4, 16'hFFFC, 1'b1, 2'b00, 6'h0);
    step();
    n_tests++; if (alu_y !== 32'hFFFFFFFC || alu_op !== 4'd15) begin n_fail++; $display("FAIL imm_sext y=%h op=%0d want FFFFFFFC/15", alu_y, alu_op); end
    n_tests++; if (out_store_data !== 32'h9 || alu_x !== 32'h7) begin n_fail++; $display("FAIL imm_sext_ops sd=%h x=%h want 9/7", out_store_data, alu_x); end
    alu_op_main = 2'b11;
    step();
    n_tests++; if (alu_y !== 32'h0000FFFC || alu_op !== 4'd1) begin n_fail++; $display("FAIL imm_zext y=%h op=%0d want 0000FFFC/1", alu_y, alu_op); end
    alu_op_main = 2'b01; alu_src = 0; imm = 16'h7FFF;
    step();
    n_tests++; if (alu_y !== 32'h9 || alu_op !== 4'd6 || illegal !== 1'b0) begin n_fail++; $display("FAIL beq_sub y=%h op=%0d ill=%b want 9/6/0", alu_y, alu_op, illegal); end
  endtask

  task automatic test_fwd();
    idle();
    drive(5'd3, 32'h5, 5'd4, 32'h6, 5'd7, 16'h0, 1'b0, 2'b10, 6'h20);
    step();
    in_valid = 0;
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h22;
    #1;
`ifdef ID_EX_FWD_EN
    n_tests++; if (alu_x !== 32'h11) begin n_fail++; $display("FAIL fwd_exmem got %h want 11", alu_x); end
    exmem_reg_write = 0;
    #1;
    n_tests++; if (alu_x !== 32'h22) begin n_fail++; $display("FAIL fwd_memwb got %h want 22", alu_x); end
    memwb_rd = 5'd4;
    #1;
    n_tests++; if (alu_y !== 32'h22 || out_store_data !== 32'h22 || alu_x !== 32'h5) begin n_fail++; $display("FAIL fwd_rt y=%h sd=%h x=%h want 22/22/5", alu_y, out_store_data, alu_x); end
    idle();
    drive(5'd0, 32'h33, 5'd0, 32'h44, 5'd1, 16'h0, 1'b0, 2'b10, 6'h20);
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'h22;
    step();
    n_tests++; if (alu_x !== 32'h33 || out_store_data !== 32'h44) begin n_fail++; $display("FAIL fwd_r0 x=%h sd=%h want 33/44", alu_x, out_store_data); end
`else
    n_tests++; if (alu_x !== 32'h5) begin n_fail++; $display("FAIL nofwd_x got %h want 5", alu_x); end
    exmem_rd = 5'd4; memwb_rd = 5'd4;
    #1;
    n_tests++; if (alu_y !== 32'h6 || out_store_data !== 32'h6) begin n_fail++; $display("FAIL nofwd_rt y=%h sd=%h want 6/6", alu_y, out_store_data); end
`endif
  endtask

  task automatic test_stall_flush();
    idle();
    drive(5'd1, 32'hA, 5'd2, 32'hAA, 5'd5, 16'h0, 1'b0, 2'b10, 6'h24);
    step();
    drive(5'd1, 32'hB, 5'd2, 32'hBB, 5'd6, 16'h0, 1'b0, 2'b10, 6'h27);
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++; if (alu_x !== 32'hA || out_rd !== 5'd5 || alu_op !== 4'd0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold c=%0d x=%h rd=%0d op=%0d v=%b want A/5/0/1", c, alu_x, out_rd, alu_op, out_valid); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c=%0d got %b want 0", c, in_ready); end
    end
    flush = 1;
    step();
    n_tests++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin n_fail++; $display("FAIL flush_bubble v=%b rw=%b want 0/0", out_valid, out_reg_write); end
    stall = 0; flush = 0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", in_ready); end
    step();
    n_tests++; if (alu_x !== 32'hB || out_rd !== 5'd6 || alu_op !== 4'd12 || out_valid !== 1'b1 || out_reg_write !== 1'b1) begin n_fail++; $display("FAIL capture_b x=%h rd=%0d op=%0d v=%b rw=%b want B/6/12/1/1", alu_x, out_rd, alu_op, out_valid, out_reg_write); end
  endtask

  task automatic test_bubble();
    idle();
    drive(5'd1, 32'h1, 5'd2, 32'h2, 5'd9, 16'h0, 1'b0, 2'b00, 6'h0);
    in_valid = 0;
    step();
    n_tests++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin n_fail++; $display("FAIL bubble_gate v=%b rw=%b want 0/0", out_valid, out_reg_write); end
  endtask

  task automatic test_async_reset();
    idle();
    drive(5'd1, 32'h1, 5'd2, 32'h2, 5'd9, 16'h0, 1'b0, 2'b10, 6'h3F);
    step();
    n_tests++; if (out_valid !== 1'b1 || illegal !== 1'b1 || out_reg_write !== 1'b1) begin n_fail++; $display("FAIL prereset v=%b ill=%b rw=%b want 1/1/1", out_valid, illegal, out_reg_write); end
    #2;
    rst_n = 0;
    #1;
    n_tests++; if ({out_valid, out_reg_write, illegal} !== 3'b000 || alu_op !== 4'd0 || out_rd !== '0) begin n_fail++; $display("FAIL async_reset v=%b rw=%b ill=%b op=%0d rd=%0d want 0", out_valid, out_reg_write, illegal, alu_op, out_rd); end
    #3;
    rst_n = 1;
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_fwd();
    test_stall_flush();
    test_bubble();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
